// File: rtl/bsg_chip_mc_link_credit_arbiter.sv
// Round-robin, credit-flow-controlled arbiter sharing the mc fwd link, with quiesce/drain FSM.
// Optional grant/stall statistics ports: define BSG_CHIP_MC_LINK_ARB_STATS_EN.
module bsg_chip_mc_link_credit_arbiter #(
    parameter int num_req_p = 4,
    parameter int width_p   = 128,
    parameter int credits_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic                           link_v_o,
    output logic [width_p-1:0]             link_data_o,
    input  logic                           link_token_i,
    input  logic                           quiesce_i,
    output logic                           idle_o,
    output logic                           credit_overflow_o
`ifdef BSG_CHIP_MC_LINK_ARB_STATS_EN
   ,output logic [num_req_p*16-1:0]        grant_count_o
   ,output logic [15:0]                    stall_count_o
`endif
);
    localparam int CW = $clog2(credits_p + 1);
    localparam int PW = $clog2(num_req_p);
    localparam logic [CW-1:0] CMAX = CW'(credits_p);
    localparam logic [CW-1:0] CONE = CW'(1);

    typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cred_q, cred_d;
    logic [PW-1:0]        ptr_q, ptr_d, win;
    logic [PW:0]          idx;
    logic                 found, grant;
    logic                 link_v_q, idle_q, ovf_q, ovf_d;
    logic [width_p-1:0]   link_data_q, link_data_d;
    logic [width_p-1:0]   req_data_a [num_req_p];

    for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
        assign req_data_a[r] = req_data_i[r*width_p +: width_p];
    end

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(num_req_p)) idx = idx - (PW+1)'(num_req_p);
            if (!found && req_v_i[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign grant      = (state_q == RUN) && !quiesce_i && (cred_q != '0) && found;
    assign req_yumi_o = grant ? (num_req_p'(1) << win) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        link_data_d = link_data_q;
        if (grant) begin
            ptr_d       = (win == PW'(num_req_p - 1)) ? '0 : win + PW'(1);
            link_data_d = req_data_a[win];
        end
    end

    always_comb begin
        cred_d = cred_q;
        ovf_d  = ovf_q;
        unique case ({grant, link_token_i})
            2'b10: cred_d = cred_q - CONE;
            2'b01: begin
                if (cred_q == CMAX) ovf_d = 1'b1;
                else                cred_d = cred_q + CONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (quiesce_i) state_d = DRAIN;
            DRAIN: begin
                if (!quiesce_i)                          state_d = RUN;
                else if (cred_q == CMAX && !link_v_q)    state_d = IDLE;
            end
            IDLE:  if (!quiesce_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            cred_q      <= CMAX;
            ptr_q       <= '0;
            link_v_q    <= 1'b0;
            link_data_q <= '0;
            idle_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cred_q      <= cred_d;
            ptr_q       <= ptr_d;
            link_v_q    <= grant;
            link_data_q <= link_data_d;
            idle_q      <= (state_d == IDLE);
            ovf_q       <= ovf_d;
        end
    end

    assign link_v_o          = link_v_q;
    assign link_data_o       = link_data_q;
    assign idle_o            = idle_q;
    assign credit_overflow_o = ovf_q;

`ifdef BSG_CHIP_MC_LINK_ARB_STATS_EN
    logic [15:0] gcnt_q [num_req_p];
    logic [15:0] stall_q;
    logic        stall;

    assign stall = (|req_v_i) && (state_q == RUN) && (cred_q == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < num_req_p; r++) gcnt_q[r] <= '0;
            stall_q <= '0;
        end else begin
            for (int r = 0; r < num_req_p; r++)
                if (req_yumi_o[r] && gcnt_q[r] != 16'hFFFF) gcnt_q[r] <= gcnt_q[r] + 16'd1;
            if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    for (genvar r = 0; r < num_req_p; r++) begin : g_pack
        assign grant_count_o[r*16 +: 16] = gcnt_q[r];
    end
    assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_bsg_chip_mc_link_credit_arbiter.sv
// Bench for bsg_chip_mc_link_credit_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_bsg_chip_mc_link_credit_arbiter;
    localparam int N  = 4;
    localparam int W  = 128;
    localparam int CP = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_v = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_yumi_o;
    logic           link_v_o;
    logic [W-1:0]   link_data_o;
    logic           tok = 1'b0;
    logic           quiesce = 1'b0;
    logic           idle_o;
    logic           credit_overflow_o;
`ifdef BSG_CHIP_MC_LINK_ARB_STATS_EN
    logic [N*16-1:0] grant_count_o;
    logic [15:0]     stall_count_o;
`endif

    bsg_chip_mc_link_credit_arbiter #(.num_req_p(N), .width_p(W), .credits_p(CP)) dut (
        .clk_i(clk), .reset_i(rst), .req_v_i(req_v), .req_data_i(req_data),
        .req_yumi_o(req_yumi_o), .link_v_o(link_v_o), .link_data_o(link_data_o),
        .link_token_i(tok), .quiesce_i(quiesce), .idle_o(idle_o),
        .credit_overflow_o(credit_overflow_o)
`ifdef BSG_CHIP_MC_LINK_ARB_STATS_EN
       ,.grant_count_o(grant_count_o), .stall_count_o(stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=running, 1=draining, 2=idle
    int           m_cred, m_ptr, m_st, m_w, m_nc, m_ns;
    bit           m_g, m_lv, m_idle, m_ovf;
    logic [W-1:0] m_ld;
    logic [N-1:0] m_yumi;

    function automatic int scan(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    always_comb begin
        m_w    = scan(m_ptr, req_v);
        m_g    = (m_st == 0) && !quiesce && (m_cred > 0) && (m_w >= 0);
        m_yumi = m_g ? N'(1) << m_w : '0;
        m_nc   = m_cred - (m_g ? 1 : 0) + (tok ? 1 : 0);
        m_ns   = m_st;
        case (m_st)
            0: if (quiesce) m_ns = 1;
            1: if (!quiesce) m_ns = 0;
               else if (m_cred == CP && !m_lv) m_ns = 2;
            default: if (!quiesce) m_ns = 0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cred <= CP; m_ptr <= 0; m_st <= 0;
            m_lv <= 1'b0; m_ld <= '0; m_idle <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_cred <= (m_nc > CP) ? CP : m_nc;
            m_ovf  <= m_ovf | (m_nc > CP);
            m_lv   <= m_g;
            if (m_g) begin
                m_ld  <= req_data[m_w*W +: W];
                m_ptr <= (m_w + 1) % N;
            end
            m_st   <= m_ns;
            m_idle <= (m_ns == 2);
        end
    end

    logic [N-1:0] obs_yumi;
    logic         obs_lv, obs_idle, obs_ovf;
    logic [W-1:0] obs_ld;

    always begin
        @(negedge clk);
        if (chk_en) begin
            check("yumi", W'(req_yumi_o), W'(m_yumi));
            check("link_v", W'(link_v_o), W'(m_lv));
            check("link_data", link_data_o, m_ld);
            check("idle", W'(idle_o), W'(m_idle));
            check("overflow", W'(credit_overflow_o), W'(m_ovf));
        end
        obs_yumi = req_yumi_o;
        obs_lv   = link_v_o;
        obs_ld   = link_data_o;
        obs_idle = idle_o;
        obs_ovf  = credit_overflow_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_v = '0; tok = 1'b0; quiesce = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [W-1:0] tag(input int r);
        return W'(128'hA0 + r);
    endfunction

    int n;
    int exp_y[6] = '{1, 2, 4, 8, 1, 2};

    initial begin
        for (int r = 0; r < N; r++) req_data[r*W +: W] = tag(r);
        #2 do_reset();
        chk_en = 1'b1;
        step();
        check("reset_link_v", W'(obs_lv), '0);
        check("reset_idle", W'(obs_idle), '0);
        check("reset_ovf", W'(obs_ovf), '0);

        // Fairness
        req_v = '1; tok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_order", W'(obs_yumi), W'(exp_y[i]));
            if (i >= 1) begin
                check("rr_link_v", W'(obs_lv), W'(1));
                check("rr_data", obs_ld, tag((i - 1) % N));
            end
        end

        // Credit exhaustion
        do_reset();
        req_v = 4'b0100; n = 0;
        repeat (20) begin step(); if (obs_yumi[2]) n++; end
        check("exhaust_count", W'(n), W'(16));
        tok = 1'b1; step(); tok = 1'b0;
        check("no_grant_at_zero", W'(obs_yumi), '0);
        n = 0;
        repeat (4) begin step(); if (obs_yumi[2]) n++; end
        check("one_more_grant", W'(n), W'(1));

        // Simultaneous grant and token at five credits
        do_reset();
        req_v = 4'b0100;
        repeat (11) step();
        tok = 1'b1; step(); tok = 1'b0;
        check("grant_with_tok", W'(obs_yumi), W'(4));
        n = 0;
        repeat (10) begin step(); if (obs_yumi[2]) n++; end
        check("five_left", W'(n), W'(5));
        tok = 1'b1; step(); tok = 1'b0;
        check("zero_tok_cycle", W'(obs_yumi), '0);
        step();
        check("grant_after_tok", W'(obs_yumi), W'(4));

        // Drain
        do_reset();
        req_v = 4'b0001;
        repeat (3) step();
        quiesce = 1'b1; req_v = '1;
        repeat (4) begin step(); check("drain_no_yumi", W'(obs_yumi), '0); end
        for (int k = 0; k < 3; k++) begin
            tok = 1'b1; step(); tok = 1'b0;
            repeat (3) step();
            if (k < 2) check("drain_not_idle", W'(obs_idle), '0);
        end
        check("drain_idle", W'(obs_idle), W'(1));
        quiesce = 1'b0; step();
        step();
        check("resume_idle_low", W'(obs_idle), '0);
        check("resume_grant", W'(obs_yumi), W'(2));

        // Overflow
        do_reset();
        repeat (2) step();
        tok = 1'b1; step(); tok = 1'b0;
        step();
        check("ovf_set", W'(obs_ovf), W'(1));
        repeat (5) step();
        check("ovf_sticky", W'(obs_ovf), W'(1));
        req_v = 4'b1000; n = 0;
        repeat (20) begin step(); if (obs_yumi[3]) n++; end
        check("ovf_saturated", W'(n), W'(16));
        do_reset(); step();
        check("ovf_cleared", W'(obs_ovf), '0);

        // Reset mid-stream
        req_v = '1; tok = 1'b1;
        repeat (5) step();
        @(posedge clk); #3 rst = 1'b1;
        #1 check("async_reset_link_v", W'(link_v_o), '0);
        req_v = 4'b1010; tok = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        step();
        check("post_reset_first", W'(obs_yumi), W'(2));

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_v = N'($urandom);
            for (int r = 0; r < N; r++)
                req_data[r*W +: W] = {$urandom, $urandom, $urandom, $urandom};
            tok = (m_cred < CP) ? ($urandom % 3 == 0) : ($urandom % 300 == 0);
            if ($urandom % 40 == 0) quiesce = ~quiesce;
            step();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
